// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal) with zero-tail frame termination.
// Optional channel error injection is enabled by defining CONV_ENC_ERRINJ_EN.
//
// state  | meaning
// S_DATA | accepting FRAME_LEN data bits from the source
// S_TAIL | emitting the two zero tail symbols that return the trellis to 00
module conv_encoder_k3 #(
  parameter int FRAME_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             sym_valid,
  output logic [1:0]       sym,
  input  logic             sym_ready,
  output logic             sym_last,
  output logic [CNT_W-1:0] frame_cnt
`ifdef CONV_ENC_ERRINJ_EN
  ,
  input  logic [1:0]       err_mask,
  output logic [7:0]       err_cnt
`endif
);

  localparam int BIT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);

  typedef enum logic {
    S_DATA = 1'b0,
    S_TAIL = 1'b1
  } state_t;

  state_t           fsm, fsm_nxt;
  logic [1:0]       s, s_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             tail_cnt, tail_cnt_nxt;
  logic             can_load;
  logic             load;
  logic             last_nxt;
  logic             u;
  logic [1:0]       code;
  logic [1:0]       code_out;

  always_comb begin
    fsm_nxt      = fsm;
    s_nxt        = s;
    bit_cnt_nxt  = bit_cnt;
    tail_cnt_nxt = tail_cnt;
    load         = 1'b0;
    last_nxt     = 1'b0;
    u            = 1'b0;
    can_load     = !sym_valid || sym_ready;
    in_ready     = (fsm == S_DATA) && can_load && !flush;

    case (fsm)
      S_DATA: begin
        u = in_bit;
        if (in_valid && in_ready) begin
          load = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt  = '0;
            tail_cnt_nxt = 1'b0;
            fsm_nxt      = S_TAIL;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      S_TAIL: begin
        if (can_load && !flush) begin
          load = 1'b1;
          if (tail_cnt) begin
            last_nxt     = 1'b1;
            tail_cnt_nxt = 1'b0;
            bit_cnt_nxt  = '0;
            fsm_nxt      = S_DATA;
          end else begin
            tail_cnt_nxt = 1'b1;
          end
        end
      end
      default: fsm_nxt = S_DATA;
    endcase

    code = {u ^ s[1] ^ s[0], u ^ s[0]};
    if (load) s_nxt = {u, s[1]};
  end

`ifdef CONV_ENC_ERRINJ_EN
  assign code_out = code ^ err_mask;
`else
  assign code_out = code;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= S_DATA;
      s        <= 2'b00;
      bit_cnt  <= '0;
      tail_cnt <= 1'b0;
    end else if (flush) begin
      fsm      <= S_DATA;
      s        <= 2'b00;
      bit_cnt  <= '0;
      tail_cnt <= 1'b0;
    end else begin
      fsm      <= fsm_nxt;
      s        <= s_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tail_cnt <= tail_cnt_nxt;
    end
  end

  // Output register: holds under backpressure, reloads on the same edge a symbol is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym       <= 2'b00;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end else if (flush) begin
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end else if (load) begin
      sym       <= code_out;
      sym_valid <= 1'b1;
      sym_last  <= last_nxt;
    end else if (sym_ready) begin
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (!flush && sym_valid && sym_ready && sym_last) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef CONV_ENC_ERRINJ_EN
  logic [8:0] err_sum;
  assign err_sum = {1'b0, err_cnt} + 9'(err_mask[0]) + 9'(err_mask[1]);

  // Not cleared by flush so a test campaign can span aborted frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (load) begin
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
`endif

endmodule
